throw_turn_ctl: RTL and testbench

//   Turn/throw initiator for the cat vs dog game; drives the enable/force/wind inputs of the cat
//   and dog throw controllers and consumes their throw_done/hit outputs. Charges throw force

---
 rtl/throw_turn_ctl.sv | 151 +++++++++++++++
 tb/tb_throw_turn_ctl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/throw_turn_ctl.sv
// Turn/throw initiator for the cat vs dog game. Charges throw force while the
// button is held, launches the active player's throw, counts at most one hit
// per throw, alternates turns with a fresh pseudo-random wind, and declares
// the winner when a player runs out of hit points.
module throw_turn_ctl #(
    parameter int         FORCE_TICK_CLKS = 650000,
    parameter int         FORCE_MAX       = 1023,
    parameter int         HP_INIT         = 5,
    parameter int         TIMEOUT_CLKS    = 650000000,
    parameter logic [6:0] LFSR_SEED       = 7'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_throw,
    input  logic       throw_done_cat,
    input  logic       throw_done_dog,
    input  logic       hit_by_cat,
    input  logic       hit_by_dog,
    output logic       enable_cat,
    output logic       enable_dog,
    output logic [9:0] throw_force,
    output logic [6:0] wind_force,
    output logic       turn,
    output logic [3:0] hp_cat,
    output logic [3:0] hp_dog,
    output logic       game_over,
    output logic       winner
);

    localparam int TW = (FORCE_TICK_CLKS > 1) ? $clog2(FORCE_TICK_CLKS) : 1;
    localparam int OW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        LAUNCH,
        RELEASE,
        GAME_OVER
    } state_t;

    state_t        state;
    logic          btn_prev;
    logic [6:0]    lfsr;
    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] tout_cnt;
    logic          hit_taken;   // a hit has already been counted this throw
    logic          timed_out;   // throw ended by timeout, skip done-low wait

    // Signals of the player whose turn it is
    logic done_act;
    logic hit_act;
    logic [6:0] wind_next;

    assign done_act  = turn ? throw_done_dog : throw_done_cat;
    assign hit_act   = turn ? hit_by_dog : hit_by_cat;
    assign wind_next = (lfsr > 7'd100) ? (lfsr - 7'd100) : lfsr;

    // Game FSM with registered outputs; LFSR and button history run every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            btn_prev    <= 1'b0;
            lfsr        <= LFSR_SEED;
            tick_cnt    <= '0;
            tout_cnt    <= '0;
            hit_taken   <= 1'b0;
            timed_out   <= 1'b0;
            enable_cat  <= 1'b0;
            enable_dog  <= 1'b0;
            throw_force <= '0;
            wind_force  <= 7'd50;
            turn        <= 1'b0;
            hp_cat      <= 4'(HP_INIT);
            hp_dog      <= 4'(HP_INIT);
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            btn_prev <= btn_throw;
            lfsr     <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};

            case (state)
                IDLE: begin
                    if (btn_throw && !btn_prev) begin
                        state       <= CHARGE;
                        throw_force <= '0;
                        tick_cnt    <= '0;
                    end
                end

                CHARGE: begin
                    if (!btn_throw) begin
                        state      <= LAUNCH;
                        enable_cat <= ~turn;
                        enable_dog <= turn;
                        tout_cnt   <= '0;
                        hit_taken  <= 1'b0;
                    end else if (tick_cnt == TW'(FORCE_TICK_CLKS - 1)) begin
                        tick_cnt <= '0;
                        if (throw_force != 10'(FORCE_MAX))
                            throw_force <= throw_force + 10'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end

                LAUNCH: begin
                    // Only the first hit of the active player's projectile counts
                    if (hit_act && !hit_taken) begin
                        hit_taken <= 1'b1;
                        if (turn) begin
                            if (hp_cat != 4'd0) hp_cat <= hp_cat - 4'd1;
                        end else begin
                            if (hp_dog != 4'd0) hp_dog <= hp_dog - 4'd1;
                        end
                    end
                    if (done_act || tout_cnt == OW'(TIMEOUT_CLKS - 1)) begin
                        state      <= RELEASE;
                        enable_cat <= 1'b0;
                        enable_dog <= 1'b0;
                        timed_out  <= ~done_act;
                    end else begin
                        tout_cnt <= tout_cnt + OW'(1);
                    end
                end

                RELEASE: begin
                    if (timed_out || !done_act) begin
                        if (hp_cat == 4'd0 || hp_dog == 4'd0) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= (hp_cat == 4'd0);
                        end else begin
                            state      <= IDLE;
                            turn       <= ~turn;
                            wind_force <= wind_next;
                        end
                    end
                end

                GAME_OVER: begin
                    enable_cat <= 1'b0;
                    enable_dog <= 1'b0;
                    game_over  <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_throw_turn_ctl.sv
// Directed bench for throw_turn_ctl with short sim parameters
// (FORCE_TICK_CLKS=4, TIMEOUT_CLKS=200, HP_INIT=2).
module tb_throw_turn_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_throw;
    logic       throw_done_cat;
    logic       throw_done_dog;
    logic       hit_by_cat;
    logic       hit_by_dog;
    logic       enable_cat;
    logic       enable_dog;
    logic [9:0] throw_force;
    logic [6:0] wind_force;
    logic       turn;
    logic [3:0] hp_cat;
    logic [3:0] hp_dog;
    logic       game_over;
    logic       winner;

    int nvec = 0;
    int nerr = 0;

    throw_turn_ctl #(
        .FORCE_TICK_CLKS(4),
        .FORCE_MAX      (1023),
        .HP_INIT        (2),
        .TIMEOUT_CLKS   (200),
        .LFSR_SEED      (7'h5A)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_throw     (btn_throw),
        .throw_done_cat(throw_done_cat),
        .throw_done_dog(throw_done_dog),
        .hit_by_cat    (hit_by_cat),
        .hit_by_dog    (hit_by_dog),
        .enable_cat    (enable_cat),
        .enable_dog    (enable_dog),
        .throw_force   (throw_force),
        .wind_force    (wind_force),
        .turn          (turn),
        .hp_cat        (hp_cat),
        .hp_dog        (hp_dog),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Hold the button for n sampled edges, release, and step into LAUNCH
    task automatic press(input int n);
        btn_throw = 1'b1;
        tick(n);
        btn_throw = 1'b0;
        tick(1);
    endtask

    task automatic pulse_cat_hit();
        hit_by_cat = 1'b1; tick(1); hit_by_cat = 1'b0; tick(1);
    endtask

    task automatic pulse_dog_hit();
        hit_by_dog = 1'b1; tick(1); hit_by_dog = 1'b0; tick(1);
    endtask

    initial begin
        rst = 1'b1; btn_throw = 1'b0;
        throw_done_cat = 1'b0; throw_done_dog = 1'b0;
        hit_by_cat = 1'b0; hit_by_dog = 1'b0;
        tick(2);
        chk("rst_en_cat", int'(enable_cat), 0);
        chk("rst_en_dog", int'(enable_dog), 0);
        chk("rst_force", int'(throw_force), 0);
        chk("rst_wind", int'(wind_force), 50);
        chk("rst_turn", int'(turn), 0);
        chk("rst_hp_cat", int'(hp_cat), 2);
        chk("rst_hp_dog", int'(hp_dog), 2);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        rst = 1'b0;
        tick(2);

        // Dog hit while idle must not count
        pulse_dog_hit();
        chk("idle_dog_hit_hp_cat", int'(hp_cat), 2);

        // Cat throw: 1 edge to enter CHARGE + 40 charging edges -> force 10
        press(41);
        chk("t1_force", int'(throw_force), 10);
        chk("t1_en_cat", int'(enable_cat), 1);
        chk("t1_en_dog", int'(enable_dog), 0);
        chk("t1_turn", int'(turn), 0);
        pulse_dog_hit();
        chk("t1_inactive_hit_hp_cat", int'(hp_cat), 2);
        pulse_cat_hit();
        chk("t1_first_hit_hp_dog", int'(hp_dog), 1);
        pulse_cat_hit();
        pulse_cat_hit();
        chk("t1_extra_hits_hp_dog", int'(hp_dog), 1);
        throw_done_cat = 1'b1;
        tick(1);
        chk("t1_release_en_cat", int'(enable_cat), 0);
        tick(2);
        chk("t1_wait_done_low_turn", int'(turn), 0);
        throw_done_cat = 1'b0;
        tick(1);
        chk("t1_turn_after", int'(turn), 1);
        chk("t1_wind_range", int'(wind_force <= 7'd100), 1);
        chk("t1_force_held", int'(throw_force), 10);

        // Dog throw that times out: force 1 after 4 charging edges
        press(5);
        chk("t2_force", int'(throw_force), 1);
        chk("t2_en_dog", int'(enable_dog), 1);
        chk("t2_en_cat", int'(enable_cat), 0);
        tick(199);
        chk("t2_en_dog_before_tout", int'(enable_dog), 1);
        tick(1);
        chk("t2_en_dog_tout", int'(enable_dog), 0);
        tick(1);
        chk("t2_turn_after_tout", int'(turn), 0);
        chk("t2_hp_cat", int'(hp_cat), 2);

        // Cat throw with long hold: force saturates at 1023
        press(5000);
        chk("t3_force_sat", int'(throw_force), 1023);
        chk("t3_en_cat", int'(enable_cat), 1);
        throw_done_cat = 1'b1; tick(1);
        throw_done_cat = 1'b0; tick(1);
        chk("t3_turn", int'(turn), 1);

        // Dog throw: one dog hit counted, cat hit (inactive) ignored
        press(2);
        chk("t4_en_dog", int'(enable_dog), 1);
        pulse_dog_hit();
        pulse_cat_hit();
        chk("t4_hp_cat", int'(hp_cat), 1);
        chk("t4_hp_dog", int'(hp_dog), 1);
        throw_done_dog = 1'b1; tick(1);
        throw_done_dog = 1'b0; tick(1);
        chk("t4_turn", int'(turn), 0);

        // Cat throw, no hit
        press(2);
        throw_done_cat = 1'b1; tick(1);
        throw_done_cat = 1'b0; tick(1);
        chk("t5_turn", int'(turn), 1);

        // Dog throw: hit and done in the same cycle -> hit counts, game over
        press(2);
        hit_by_dog = 1'b1; throw_done_dog = 1'b1;
        tick(1);
        hit_by_dog = 1'b0;
        chk("t6_hp_cat", int'(hp_cat), 0);
        chk("t6_en_dog", int'(enable_dog), 0);
        throw_done_dog = 1'b0;
        tick(1);
        chk("t6_game_over", int'(game_over), 1);
        chk("t6_winner", int'(winner), 1);
        press(10);
        tick(3);
        chk("t6_btn_ignored_en_cat", int'(enable_cat), 0);
        chk("t6_btn_ignored_en_dog", int'(enable_dog), 0);
        chk("t6_game_over_held", int'(game_over), 1);

        // Fresh game, then reset in the middle of a cat launch
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        chk("t7_game_over_clr", int'(game_over), 0);
        press(5);
        pulse_cat_hit();
        chk("t7_hp_dog", int'(hp_dog), 1);
        chk("t7_en_cat", int'(enable_cat), 1);
        rst = 1'b1;
        #1;
        chk("t7_async_en_cat", int'(enable_cat), 0);
        chk("t7_hp_dog_rst", int'(hp_dog), 2);
        chk("t7_hp_cat_rst", int'(hp_cat), 2);
        chk("t7_turn_rst", int'(turn), 0);
        chk("t7_wind_rst", int'(wind_force), 50);
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
